// File: rtl/accel_mem_responder.sv
// rtl/accel_mem_responder.sv - wait-stated word memory responder with host preload port
// Single-initiator read/write engine: IDLE -> WAIT -> ACCESS -> DONE, abort on request change.
module accel_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               mem_operation,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              data_i,
  output logic [31:0]              data_o,
  output logic                     mem_opdone,
  output logic                     err,
  output logic                     busy,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [31:0]              host_wdata,
  output logic [31:0]              host_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [1:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    cnt_q;
  logic [31:0]   data_q;
  logic          done_q;
  logic          err_q;
  logic          busy_q;

  logic [31:0]   mem_q [DEPTH];

  logic          req_valid;
  logic          abort;
  logic          in_range;
  logic [31:0]   rd_word;
  logic          mem_we_d;
  logic [AW-1:0] mem_waddr_d;
  logic [31:0]   mem_wdata_d;

  assign req_valid = (mem_operation == OP_RD) || (mem_operation == OP_WR);
  // The initiator must hold both op and address steady for the whole transaction.
  assign abort     = (mem_operation != op_q) || (addr_i != addr_q);
  assign in_range  = (addr_q[31:AW] == '0);
  assign rd_word   = mem_q[addr_q[AW-1:0]];

  assign host_rdata = mem_q[host_addr];
  assign data_o     = data_q;
  assign mem_opdone = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

  // One write port shared by the transaction commit and the host preload path.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = host_addr;
    mem_wdata_d = host_wdata;
    if (reset_n) begin
      if (state_q == S_ACCESS && !abort && op_q == OP_WR && in_range) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = addr_q[AW-1:0];
        mem_wdata_d = wdata_q;
      end else if (state_q == S_IDLE && mem_operation == OP_NONE && host_we) begin
        mem_we_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= mem_operation;
            addr_q  <= addr_i;
            wdata_q <= data_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end else if (mem_operation == OP_RSVD) begin
            err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == WAIT_LAST) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_ACCESS: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= !in_range;
            if (op_q == OP_RD) begin
              data_q <= in_range ? rd_word : 32'h0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_mem_responder.sv
// tb/tb_accel_mem_responder.sv - directed bench for accel_mem_responder (DEPTH=256, WAIT_CYCLES=2)
module tb_accel_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_operation;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        mem_opdone;
  logic        err;
  logic        busy;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;

  int total = 0;
  int bad   = 0;

  accel_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_operation(mem_operation),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .mem_opdone   (mem_opdone),
    .err          (err),
    .busy         (busy),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic hw(input logic [7:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_we = 1'b0;
  endtask

  // Runs five cycles of one transaction; request is dropped while DONE is showing.
  task automatic xact(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      output logic [4:0] dp, output logic [4:0] ep);
    mem_operation = op; addr_i = a; data_i = d;
    for (int i = 0; i < 5; i++) begin
      step();
      dp[i] = mem_opdone;
      ep[i] = err;
      if (i == 3) mem_operation = 2'b00;
    end
  endtask

  initial begin
    logic [4:0]  dp;
    logic [4:0]  ep;
    logic [31:0] seen [4];
    int          pulses;
    int          consec;
    logic        prev;
    logic [3:0]  acc;

    reset_n = 1'b0; mem_operation = 2'b00; addr_i = '0; data_i = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    @(negedge clk);
    step(); step();
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_opdone", {31'h0, mem_opdone}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) hw(8'(i), 32'h0000_00A0 + 32'(i));
    hw(8'd5, 32'hDEAD_BEEF);
    hw(8'd9, 32'h0000_0099);
    hw(8'd44, 32'h0000_0044);
    host_addr = 8'd5;
    chk("preload_5", host_rdata, 32'hDEAD_BEEF);

    xact(2'b01, 32'd5, 32'h0, dp, ep);
    chk("rd5_done_timing", {27'h0, dp}, 32'h08);
    chk("rd5_err", {27'h0, ep}, 32'h0);
    chk("rd5_data", data_o, 32'hDEAD_BEEF);
    chk("rd5_busy_after", {31'h0, busy}, 32'h0);

    xact(2'b11, 32'd7, 32'h1234_5678, dp, ep);
    chk("wr7_done_timing", {27'h0, dp}, 32'h08);
    chk("wr7_data_o_kept", data_o, 32'hDEAD_BEEF);
    host_addr = 8'd7;
    chk("wr7_host_rdata", host_rdata, 32'h1234_5678);
    xact(2'b01, 32'd7, 32'h0, dp, ep);
    chk("rd7_data", data_o, 32'h1234_5678);

    mem_operation = 2'b01; addr_i = 32'd0;
    pulses = 0; consec = 0; prev = 1'b0;
    for (int c = 0; c < 60 && pulses < 4; c++) begin
      step();
      if (mem_opdone && prev) consec++;
      prev = mem_opdone;
      if (mem_opdone) begin
        seen[pulses] = data_o;
        pulses++;
        addr_i = 32'(pulses);
        if (pulses == 4) mem_operation = 2'b00;
      end
    end
    step(); step();
    chk("b2b_pulses", 32'(pulses), 32'd4);
    chk("b2b_consecutive", 32'(consec), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_data%0d", i), seen[i], 32'h0000_00A0 + 32'(i));

    xact(2'b11, 32'd300, 32'h5555_5555, dp, ep);
    chk("oor_wr_done", {27'h0, dp}, 32'h08);
    chk("oor_wr_err", {27'h0, ep}, 32'h08);
    host_addr = 8'd44;
    chk("oor_wr_mem_alias", host_rdata, 32'h0000_0044);
    xact(2'b01, 32'd300, 32'h0, dp, ep);
    chk("oor_rd_err", {27'h0, ep}, 32'h08);
    chk("oor_rd_data", data_o, 32'h0);

    mem_operation = 2'b10;
    step();
    chk("rsvd_err", {31'h0, err}, 32'h1);
    chk("rsvd_busy", {31'h0, busy}, 32'h0);
    chk("rsvd_opdone", {31'h0, mem_opdone}, 32'h0);
    mem_operation = 2'b00;
    step();
    chk("rsvd_err_clear", {31'h0, err}, 32'h0);

    mem_operation = 2'b11; addr_i = 32'd9; data_i = 32'h0000_0BAD;
    step();
    chk("abort_busy_wait", {31'h0, busy}, 32'h1);
    mem_operation = 2'b00;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc[i] = mem_opdone | err;
    end
    chk("abort_no_pulse", {28'h0, acc}, 32'h0);
    chk("abort_busy_idle", {31'h0, busy}, 32'h0);
    host_addr = 8'd9;
    chk("abort_mem9", host_rdata, 32'h0000_0099);

    mem_operation = 2'b11; addr_i = 32'd9; data_i = 32'h0000_0BAD;
    step(); step(); step();
    reset_n = 1'b0;
    step();
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_data_o", data_o, 32'h0);
    reset_n = 1'b1; mem_operation = 2'b00;
    step();
    chk("rst_mid_opdone", {31'h0, mem_opdone}, 32'h0);
    chk("rst_mid_mem9", host_rdata, 32'h0000_0099);

    mem_operation = 2'b01; addr_i = 32'd9;
    step();
    host_we = 1'b1; host_addr = 8'd9; host_wdata = 32'h0000_0777;
    step(); step(); step();
    chk("hwe_rd_opdone", {31'h0, mem_opdone}, 32'h1);
    chk("hwe_rd_data", data_o, 32'h0000_0099);
    host_we = 1'b0; mem_operation = 2'b00;
    step();
    chk("hwe_dropped", host_rdata, 32'h0000_0099);

    host_we = 1'b1; host_addr = 8'd2; host_wdata = 32'h0000_FFFF;
    mem_operation = 2'b01; addr_i = 32'd2;
    step();
    host_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) mem_operation = 2'b00;
    end
    chk("req_wins_data", data_o, 32'h0000_00A2);
    chk("req_wins_mem", host_rdata, 32'h0000_00A2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
